vga_timing_gen: RTL

- Consumes the 25 MHz pixel strobe from the clock divider and generates 640x480@60 Hz VGA timing: horizontal/vertical counters, hsync/vsync, active-video flag and pixel coordinates.
- Also produces single-clock event pulses (line end, frame end, animate) for the Snake game logic and pixel renderer downstream.
- All logic runs on the system clk. pix_stb is a clock enable, not a clock.

---
 rtl/vga_timing_gen.sv | 93 +++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator running on clk and stepped by the pix_stb enable.
// Sync/active levels are computed from the next counter values, so they line up with x/y.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_stb,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_end,
  output logic       frame_end,
  output logic       animate
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ALAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  V_ALAST = 10'(V_ACTIVE - 1);

  // Region bounds held at 11 bits: a sync end can sit exactly at 1024.
  localparam logic [10:0] H_ACT_END = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT_END = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON = (SYNC_POL != 0);

  logic       h_wrap, v_wrap;
  logic [9:0] h_nxt, v_nxt;
  logic [10:0] h_nxt_w, v_nxt_w;
  logic       hs_nxt, vs_nxt, act_nxt, anim_hit;

  always_comb begin
    h_wrap   = (x == H_LAST);
    v_wrap   = (y == V_LAST);
    h_nxt    = h_wrap ? 10'd0 : x + 10'd1;
    v_nxt    = y;
    if (h_wrap)
      v_nxt  = v_wrap ? 10'd0 : y + 10'd1;
    h_nxt_w  = {1'b0, h_nxt};
    v_nxt_w  = {1'b0, v_nxt};
    hs_nxt   = (h_nxt_w >= HS_START) && (h_nxt_w < HS_END);
    vs_nxt   = (v_nxt_w >= VS_START) && (v_nxt_w < VS_END);
    act_nxt  = (h_nxt_w < H_ACT_END) && (v_nxt_w < V_ACT_END);
    // Leaving the last visible pixel of the frame opens vertical blanking.
    anim_hit = (x == H_ALAST) && (y == V_ALAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      active    <= 1'b1;
      hsync     <= ~SYNC_ON;
      vsync     <= ~SYNC_ON;
      line_end  <= 1'b0;
      frame_end <= 1'b0;
      animate   <= 1'b0;
    end else begin
      line_end  <= 1'b0;
      frame_end <= 1'b0;
      animate   <= 1'b0;
      if (pix_stb) begin
        x         <= h_nxt;
        y         <= v_nxt;
        active    <= act_nxt;
        hsync     <= hs_nxt ? SYNC_ON : ~SYNC_ON;
        vsync     <= vs_nxt ? SYNC_ON : ~SYNC_ON;
        line_end  <= h_wrap;
        frame_end <= h_wrap && v_wrap;
        animate   <= anim_hit;
      end
    end
  end

endmodule
